disp_scan_drv: RTL and testbench



---
 rtl/disp_pkg.sv | 22 ++
 rtl/disp_scan_drv_if.sv | 27 ++
 rtl/hex7seg.sv | 11 +
 rtl/disp_scan_drv.sv | 113 +++++++++++
 tb/tb_disp_scan_drv.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {
    StIdle,
    StScan
  } state_e;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/disp_scan_drv_if.sv
// Producer-side handshake bundle: word, masks and valid/ready.
interface disp_scan_drv_if;
  import disp_pkg::*;

  logic [31:0]           data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] point_mask;

  modport master (
    output data_in,
    output data_valid,
    output blank_mask,
    output point_mask,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  blank_mask,
    input  point_mask,
    output data_ready
  );

endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low 7-segment pattern.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/disp_scan_drv.sv
// Time-multiplexes a 32-bit word as hex digits onto active-low anodes/cathodes.
// New words load only at frame boundaries so a frame never mixes old and new digits.
module disp_scan_drv
  import disp_pkg::*;
#(
  parameter int unsigned CLK_DIV_W = 17,
  parameter int unsigned DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  disp_scan_drv_if.slave        bus,
  output logic [7:0]            an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  state_e               state_q, state_d;
  logic [CLK_DIV_W-1:0] div_q, div_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [31:0]          word_q, word_d;
  logic [7:0]           blank_q, blank_d;
  logic [7:0]           point_q, point_d;
  logic [7:0]           an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic                 frame_done_q, frame_done_d;

  logic                 frame_end;
  logic                 accept;
  logic [6:0]           hex_pat;

  assign frame_end      = (state_q == StScan) && (&div_q) && (idx_q == LastIdx);
  assign bus.data_ready = (state_q == StIdle) || frame_end;
  assign accept         = bus.data_valid && bus.data_ready;

  // Pattern is looked up from the next-state digit so the display tracks idx without lag.
  hex7seg u_hex7seg (
    .nibble_i (word_d[{idx_d, 2'b00} +: 4]),
    .seg_o    (hex_pat)
  );

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    idx_d        = idx_q;
    word_d       = word_q;
    blank_d      = blank_q;
    point_d      = point_q;
    frame_done_d = frame_end;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StScan;
          div_d   = '0;
          idx_d   = '0;
        end
      end
      StScan: begin
        div_d = div_q + 1'b1;
        if (&div_q) begin
          idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      word_d  = bus.data_in;
      blank_d = bus.blank_mask;
      point_d = bus.point_mask;
    end

    if (state_d == StIdle) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end else begin
      an_d  = blank_d[idx_d] ? AN_OFF : ~(8'b1 << idx_d);
      seg_d = {~point_d[idx_d], hex_pat};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      div_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      blank_q      <= '0;
      point_q      <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      blank_q      <= blank_d;
      point_q      <= point_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_drv.sv
// Scoreboard bench: the driver predicts each post-edge display from a time-since-load
// model and queues it; a monitor pops and compares after every rising edge.
module tb_disp_scan_drv;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic       rdy;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] an, seg;
  logic       frame_done;

  disp_scan_drv_if bus ();

  disp_scan_drv #(
    .CLK_DIV_W (2),
    .DIGITS    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference digit glyphs with the decimal point off.
  logic [7:0] glyph [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_seen = 0;

  // Model: m_t counts cycles since the last load; a frame is 32 cycles, a digit 4.
  bit         m_run = 0;
  int         m_t   = 0;
  logic [31:0] m_word;
  logic [7:0]  m_bm, m_pm;
  int         m_accepts = 0;
  bit         m_last_acc = 0;

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [31:0] d,
                      input logic [7:0] bm, input logic [7:0] pm);
    exp_t e;
    bit   bnd;
    int   dig;
    rst_n          = rst;
    bus.data_valid = v;
    bus.data_in    = d;
    bus.blank_mask = bm;
    bus.point_mask = pm;
    bnd        = m_run && (m_t % 32 == 31);
    m_last_acc = 0;
    if (!rst) begin
      m_run = 0;
    end else if ((!m_run || bnd) && v) begin
      m_run = 1; m_t = 0; m_word = d; m_bm = bm; m_pm = pm;
      m_last_acc = 1; m_accepts++;
    end else if (m_run) begin
      m_t++;
    end
    e.fd = rst && bnd;
    if (!m_run) begin
      e.an = 8'hFF; e.seg = 8'hFF; e.rdy = 1'b1;
    end else begin
      dig   = (m_t / 4) % 8;
      e.an  = m_bm[dig] ? 8'hFF : ~(8'h01 << dig);
      e.seg = glyph[(m_word >> (4 * dig)) & 32'hF];
      if (m_pm[dig]) e.seg = e.seg & 8'h7F;
      e.rdy = (m_t % 32 == 31);
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold_until_accept(input logic [31:0] d, input logic [7:0] bm,
                                   input logic [7:0] pm);
    for (int i = 0; i < 64; i++) begin
      step(1, 1, d, bm, pm);
      if (m_last_acc) break;
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (rst_n && bus.data_valid && bus.data_ready) hs_seen++;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check8("an", an, e.an);
      // seg content is unspecified while a digit is blanked during scan
      if (e.an != 8'hFF || e.seg == 8'hFF) check8("seg", seg, e.seg);
      check8("data_ready", {7'd0, bus.data_ready}, {7'd0, e.rdy});
      check8("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    rst_n = 0; bus.data_valid = 0; bus.data_in = '0; bus.blank_mask = '0; bus.point_mask = '0;
    // Reset then idle
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, '0);
    for (int i = 0; i < 10; i++) step(1, 0, '0, '0, '0);
    // First load
    step(1, 1, 32'h1234_ABCD, 8'h00, 8'h00);
    for (int i = 0; i < 12; i++) step(1, 0, '0, '0, '0);
    // Backpressure: valid mid-frame until the boundary
    hold_until_accept(32'hDEAD_BEEF, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) step(1, 0, '0, '0, '0);
    // Masks
    hold_until_accept(32'h0000_0000, 8'hF0, 8'h01);
    for (int i = 0; i < 34; i++) step(1, 0, '0, '0, '0);
    // Reset mid-scan at digit 3
    for (int i = 0; i < 64; i++) begin
      if (m_run && ((m_t + 1) / 4) % 8 == 3) break;
      step(1, 0, '0, '0, '0);
    end
    step(0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, '0, '0);
    step(1, 1, $urandom, 8'h00, 8'h00);
    for (int i = 0; i < 40; i++) step(1, 0, '0, '0, '0);
    // Continuous valid with changing data
    for (int i = 0; i < 110; i++) begin
      w = $urandom;
      step(1, 1, w, 8'($urandom), 8'($urandom));
    end
    // Random mix, rare resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0), $urandom,
           8'($urandom), 8'($urandom));
    end
    step(1, 0, '0, '0, '0);
    @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
    end
    n_tests++;
    if (hs_seen != m_accepts) begin
      n_fail++;
      $display("FAIL handshakes: got %0d, expected %0d", hs_seen, m_accepts);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
